gbfflgofm_ctrl: RTL

GBFFLGOFM_CTRL -- requirements
Module: gbfflgofm_ctrl

---
 rtl/gbfflgofm_pkg.sv | 24 ++
 rtl/gbfflgofm_skid.sv | 72 +++++++
 rtl/gbfflgofm_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gbfflgofm_pkg.sv
// gbfflgofm_pkg -- shared constants and types for the gbfflgofm FIFO controller.
// Holds the default RAM geometry, the output skid depth and the read/write
// arbitration turn encoding used by the controller and its skid buffer.
package gbfflgofm_pkg;

   localparam int DEFAULT_SRAM_DEPTH_BIT = 6;
   localparam int DEFAULT_SRAM_WIDTH     = 28;
   localparam int SKID_DEPTH             = 2;
   localparam int SKID_CNT_W             = $clog2(SKID_DEPTH + 1);

   typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

   // Whose turn it is to use the single RAM port when a read is possible.
   typedef enum logic {
      TURN_WR = 1'b0,
      TURN_RD = 1'b1
   } turn_t;

   // A new read may only be launched if its data is sure to find a free skid slot.
   function automatic logic pipe_has_room(input skid_cnt_t skid_cnt, input logic rd_inflight);
      return ({1'b0, skid_cnt} + {{SKID_CNT_W{1'b0}}, rd_inflight}) < (SKID_CNT_W + 1)'(SKID_DEPTH);
   endfunction

endpackage

// File: rtl/gbfflgofm_skid.sv
// gbfflgofm_skid -- two-entry output skid buffer for the gbfflgofm controller.
// Entry 0 is always the oldest word and drives the consumer directly; entry 1
// holds the next word while the consumer stalls.
module gbfflgofm_skid
   import gbfflgofm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_SRAM_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] head_data,
   output skid_cnt_t        cnt
);

   localparam skid_cnt_t SKID_ONE  = skid_cnt_t'(1);
   localparam skid_cnt_t SKID_FULL = skid_cnt_t'(SKID_DEPTH);

   logic [WIDTH-1:0] entry0;
   logic [WIDTH-1:0] entry1;
   skid_cnt_t        fill;
   logic             do_pop;

   assign do_pop    = pop && (fill != '0);
   assign valid     = (fill != '0);
   assign head_data = entry0;
   assign cnt       = fill;

   // Shift-style storage: pops move entry 1 down, pushes land in the first free slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill   <= '0;
         entry0 <= '0;
         entry1 <= '0;
      end else if (clear) begin
         fill   <= '0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (fill == '0) begin
                  entry0 <= push_data;
                  fill   <= fill + SKID_ONE;
               end else if (fill != SKID_FULL) begin
                  entry1 <= push_data;
                  fill   <= fill + SKID_ONE;
               end
            end
            2'b01: begin
               entry0 <= entry1;
               fill   <= fill - SKID_ONE;
            end
            2'b11: begin
               if (fill == SKID_ONE) begin
                  entry0 <= push_data;
               end else begin
                  entry0 <= entry1;
                  entry1 <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/gbfflgofm_ctrl.sv
// gbfflgofm_ctrl -- circular-FIFO controller around a single-port RAM with a
// two-entry output skid buffer. Reads and writes share the RAM port: a read is
// granted at most every other cycle and always wins over a write in its cycle.
// Optional feature: define GBFFLGOFM_ERR_CHK_EN to enable the sticky producer
// protocol checker on err (in_vld dropped or in_data changed while stalled).
module gbfflgofm_ctrl
   import gbfflgofm_pkg::*;
#(
   parameter int SRAM_DEPTH_BIT = DEFAULT_SRAM_DEPTH_BIT,
   parameter int SRAM_WIDTH     = DEFAULT_SRAM_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [SRAM_WIDTH-1:0]     in_data,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [SRAM_WIDTH-1:0]     out_data,
   output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
   output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
   output logic                      ram_read_en,
   output logic                      ram_write_en,
   output logic [SRAM_WIDTH-1:0]     ram_data_in,
   input  logic [SRAM_WIDTH-1:0]     ram_data_out,
   output logic [SRAM_DEPTH_BIT:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      err
);

   localparam logic [SRAM_DEPTH_BIT:0]   DEPTH_CNT = (SRAM_DEPTH_BIT + 1)'(2 ** SRAM_DEPTH_BIT);
   localparam logic [SRAM_DEPTH_BIT:0]   CNT_ONE   = (SRAM_DEPTH_BIT + 1)'(1);
   localparam logic [SRAM_DEPTH_BIT-1:0] PTR_ONE   = SRAM_DEPTH_BIT'(1);

   logic [SRAM_DEPTH_BIT-1:0] wp;
   logic [SRAM_DEPTH_BIT-1:0] rp;
   logic [SRAM_DEPTH_BIT:0]   cnt_q;
   turn_t                     turn_rd;
   logic                      rd_inflight;
   logic                      can_read;
   logic                      rd_grant;
   logic                      wr_fire;
   skid_cnt_t                 skid_cnt;

   assign full     = (cnt_q == DEPTH_CNT);
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign can_read = !empty && pipe_has_room(skid_cnt, rd_inflight);
   assign rd_grant = can_read && (turn_rd == TURN_RD);

   // The producer is stalled whenever the RAM port is taken by a read.
   assign in_rdy   = !full && !rd_grant && !clear;
   assign wr_fire  = in_vld && in_rdy;

   assign ram_write_en = wr_fire;
   assign ram_addr_w   = wp;
   assign ram_data_in  = in_data;
   assign ram_read_en  = rd_grant;
   assign ram_addr_r   = rp;

   // Pointer, occupancy and read-pipeline bookkeeping; reads and writes are mutually exclusive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp          <= '0;
         rp          <= '0;
         cnt_q       <= '0;
         turn_rd     <= TURN_WR;
         rd_inflight <= 1'b0;
      end else if (clear) begin
         wp          <= '0;
         rp          <= '0;
         cnt_q       <= '0;
         turn_rd     <= TURN_WR;
         rd_inflight <= 1'b0;
      end else begin
         turn_rd     <= rd_grant ? TURN_WR : TURN_RD;
         rd_inflight <= rd_grant;
         if (wr_fire) begin
            wp    <= wp + PTR_ONE;
            cnt_q <= cnt_q + CNT_ONE;
         end else if (rd_grant) begin
            rp    <= rp + PTR_ONE;
            cnt_q <= cnt_q - CNT_ONE;
         end
      end
   end

   gbfflgofm_skid #(
      .WIDTH (SRAM_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (rd_inflight),
      .push_data (ram_data_out),
      .pop       (out_rdy),
      .valid     (out_vld),
      .head_data (out_data),
      .cnt       (skid_cnt)
   );

`ifdef GBFFLGOFM_ERR_CHK_EN
   logic                  stall_q;
   logic [SRAM_WIDTH-1:0] stall_data_q;
   logic                  err_q;

   // Remember a stalled offer and flag it if the producer withdraws or alters it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q      <= 1'b0;
         stall_data_q <= '0;
         err_q        <= 1'b0;
      end else if (clear) begin
         stall_q      <= 1'b0;
         stall_data_q <= '0;
         err_q        <= 1'b0;
      end else begin
         stall_q      <= in_vld && !in_rdy;
         stall_data_q <= in_data;
         if (stall_q && (!in_vld || (in_data != stall_data_q))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
